// File: rtl/reservation_table_if.sv
`default_nettype none
// ============================================================================
//  Module      : reservation_table_if
//  Description : Memory-stage to reservation-table bundle. The memory stage
//                presents one tagged access per cycle and receives the
//                registered SC result and the per-hart reservation vector.
//  Signals     : i_hart_id          hart issuing the current access
//                i_addr             access address
//                i_store_op         plain store this cycle
//                i_store_cond_op    SC.W this cycle
//                i_load_reserved_op LR.W this cycle
//                o_sc_success       registered result of the previous-cycle SC
//                o_sc_hart_id       hart the o_sc_success result belongs to
//                o_resv_valid       per-hart reservation-valid vector
//  Modports    : master (memory stage), slave (reservation table)
//  Revision    : 1.0 - initial release
// ============================================================================
interface reservation_table_if #(
    parameter int NUM_HARTS = 16,
    parameter int HART_ID_W = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1,
    parameter int ADDR_W    = 12
);
    logic [HART_ID_W-1:0] i_hart_id;
    logic [ADDR_W-1:0]    i_addr;
    logic                 i_store_op;
    logic                 i_store_cond_op;
    logic                 i_load_reserved_op;
    logic                 o_sc_success;
    logic [HART_ID_W-1:0] o_sc_hart_id;
    logic [NUM_HARTS-1:0] o_resv_valid;

    modport master (
        output i_hart_id, i_addr, i_store_op, i_store_cond_op, i_load_reserved_op,
        input  o_sc_success, o_sc_hart_id, o_resv_valid
    );

    modport slave (
        input  i_hart_id, i_addr, i_store_op, i_store_cond_op, i_load_reserved_op,
        output o_sc_success, o_sc_hart_id, o_resv_valid
    );
endinterface
`default_nettype wire

// File: rtl/reservation_table.sv
`default_nettype none
// ============================================================================
//  Module      : reservation_table
//  Description : Multi-hart LR/SC reservation tracker. One reservation
//                (valid + granule tag) per hart. LR sets the issuing hart's
//                entry; SC checks and always clears it, and a successful SC
//                or any plain store clears every matching reservation.
//                Op priority when several bits are set: LR > SC > store.
//                Accesses from a hart ID >= NUM_HARTS change no state; an SC
//                from such a hart reports failure.
//  Ports       : clk      - clock, rising edge
//                reset_n  - asynchronous active-low reset
//                bus      - reservation_table_if.slave (access + results)
//  Option      : RESV_TIMEOUT_EN - when defined, every reservation expires
//                TIMEOUT_CYCLES cycles after its LR; an SC in the expiring
//                cycle fails.
//  Revision    : 1.0 - initial release
// ============================================================================
module reservation_table #(
    parameter int NUM_HARTS      = 16,
    parameter int HART_ID_W      = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1,
    parameter int ADDR_W         = 12,
    parameter int GRANULE_LSB    = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  wire logic            clk,
    input  wire logic            reset_n,
    reservation_table_if.slave   bus
);

    localparam int TAG_W = ADDR_W - GRANULE_LSB;

    // ------------------------------------------------------------------
    // Op decode with priority LR > SC > store
    // ------------------------------------------------------------------
    logic             w_lr;
    logic             w_sc;
    logic             w_st;
    logic [TAG_W-1:0] w_tag;

    assign w_lr  = bus.i_load_reserved_op;
    assign w_sc  = bus.i_store_cond_op & ~w_lr;
    assign w_st  = bus.i_store_op & ~w_lr & ~bus.i_store_cond_op;
    assign w_tag = bus.i_addr[ADDR_W-1:GRANULE_LSB];

    // Address bits below the granule never take part in a compare.
    generate
        if (GRANULE_LSB > 0) begin : g_lsb_unused
            logic w_unused_lsb;
            assign w_unused_lsb = ^bus.i_addr[(GRANULE_LSB > 0 ? GRANULE_LSB - 1 : 0):0];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Entry state
    // ------------------------------------------------------------------
    logic [NUM_HARTS-1:0] r_valid;
    logic [TAG_W-1:0]     r_tag [NUM_HARTS];

    logic [NUM_HARTS-1:0] w_sel;     // one-hot decode of i_hart_id (zero if out of range)
    logic [NUM_HARTS-1:0] w_hit;     // valid entry whose granule matches i_addr
    logic [NUM_HARTS-1:0] w_live;    // hit that an SC may still consume
    logic [NUM_HARTS-1:0] w_expire;  // entry times out on this edge
    logic [NUM_HARTS-1:0] w_set;
    logic [NUM_HARTS-1:0] w_kill;
    logic                 w_hart_ok;
    logic                 w_sc_success;

    generate
        for (genvar k = 0; k < NUM_HARTS; k++) begin : g_entry
            assign w_sel[k] = (bus.i_hart_id == HART_ID_W'(k));
            assign w_hit[k] = r_valid[k] && (r_tag[k] == w_tag);
        end
    endgenerate

`ifdef RESV_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt [NUM_HARTS];

    // A count of 1 means the reservation dies on this edge, so an SC
    // arriving now must already see it as gone.
    generate
        for (genvar k = 0; k < NUM_HARTS; k++) begin : g_expire
            assign w_expire[k] = r_valid[k] && (r_cnt[k] == CNT_W'(1));
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NUM_HARTS; k++) begin
                r_cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_HARTS; k++) begin
                if (w_set[k]) begin
                    r_cnt[k] <= CNT_W'(TIMEOUT_CYCLES);
                end else if (w_kill[k]) begin
                    r_cnt[k] <= '0;
                end else if (r_valid[k]) begin
                    r_cnt[k] <= r_cnt[k] - CNT_W'(1);
                end
            end
        end
    end
`else
    assign w_expire = '0;
`endif

    assign w_live       = w_hit & ~w_expire;
    assign w_hart_ok    = |w_sel;
    assign w_sc_success = w_sc && |(w_sel & w_live);

    // LR only touches the issuer's entry. An SC always consumes the
    // issuer's entry; when it succeeds it is a real write and therefore
    // also kills every other matching reservation, exactly like a store.
    assign w_set  = w_lr ? w_sel : '0;
    assign w_kill = (w_sc ? w_sel : '0)
                  | ((w_sc_success || (w_st && w_hart_ok)) ? w_hit : '0)
                  | w_expire;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= '0;
        end else begin
            r_valid <= (r_valid & ~w_kill) | w_set;
        end
    end

    // Tags are qualified by r_valid, so they need no reset.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_HARTS; k++) begin
            if (w_set[k]) begin
                r_tag[k] <= w_tag;
            end
        end
    end

    // ------------------------------------------------------------------
    // SC result, one cycle after the SC
    // ------------------------------------------------------------------
    logic                 r_sc_success;
    logic [HART_ID_W-1:0] r_sc_hart_id;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sc_success <= 1'b0;
            r_sc_hart_id <= '0;
        end else begin
            r_sc_success <= w_sc_success;
            if (w_sc) begin
                r_sc_hart_id <= bus.i_hart_id;
            end
        end
    end

    assign bus.o_sc_success = r_sc_success;
    assign bus.o_sc_hart_id = r_sc_hart_id;
    assign bus.o_resv_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_reservation_table.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reservation_table
//  Description : Bench for reservation_table. A reservation is modelled as
//                (valid, address, cycle of its LR); liveness under the
//                timeout option is derived from elapsed cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reservation_table;

    localparam int NH = 12;
    localparam int HW = 4;
    localparam int AW = 12;
    localparam int GL = 2;
    localparam int TO = 4;
`ifdef RESV_TIMEOUT_EN
    localparam bit TO_ON = 1'b1;
`else
    localparam bit TO_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    reservation_table_if #(.NUM_HARTS(NH), .HART_ID_W(HW), .ADDR_W(AW)) bus ();

    reservation_table #(
        .NUM_HARTS(NH), .HART_ID_W(HW), .ADDR_W(AW),
        .GRANULE_LSB(GL), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    // ---------------- reference model ----------------
    bit            m_valid [NH];
    logic [AW-1:0] m_addr  [NH];
    int            m_lr    [NH];
    int            cyc;
    bit            exp_sc;
    logic [HW-1:0] exp_hid;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic bit gm(input logic [AW-1:0] a, input logic [AW-1:0] b);
        return a[AW-1:GL] == b[AW-1:GL];
    endfunction

    // Usable by an SC in cycle c: dies once TO cycles have passed since the LR.
    function automatic bit live(input int k, input int c);
        return m_valid[k] && (!TO_ON || (c < m_lr[k] + TO));
    endfunction

    // Shown on o_resv_valid during cycle c.
    function automatic bit vis(input int k, input int c);
        return m_valid[k] && (!TO_ON || (c <= m_lr[k] + TO));
    endfunction

    task automatic check_outputs(input string pfx);
        logic [NH-1:0] v;
        for (int k = 0; k < NH; k++) v[k] = vis(k, cyc);
        chk({pfx, "_sc_ok"},   32'(bus.o_sc_success), 32'(exp_sc));
        chk({pfx, "_sc_hart"}, 32'(bus.o_sc_hart_id), 32'(exp_hid));
        chk({pfx, "_resv"},    32'(bus.o_resv_valid), 32'(v));
    endtask

    // Called at posedge+1: apply one access, update the model, check after the edge.
    task automatic step(input int h, input logic [AW-1:0] a, input bit lr, input bit sc, input bit st);
        bit ok;
        bit s;
        ok = (h < NH);
        s  = 1'b0;
        bus.i_hart_id          = HW'(h);
        bus.i_addr             = a;
        bus.i_load_reserved_op = lr;
        bus.i_store_cond_op    = sc;
        bus.i_store_op         = st;
        if (lr) begin
            if (ok) begin
                m_valid[h] = 1'b1;
                m_addr[h]  = a;
                m_lr[h]    = cyc;
            end
        end else if (sc) begin
            exp_hid = HW'(h);
            if (ok) begin
                s = live(h, cyc) && gm(m_addr[h], a);
                m_valid[h] = 1'b0;
                if (s) begin
                    for (int k = 0; k < NH; k++)
                        if (live(k, cyc) && gm(m_addr[k], a)) m_valid[k] = 1'b0;
                end
            end
        end else if (st && ok) begin
            for (int k = 0; k < NH; k++)
                if (m_valid[k] && gm(m_addr[k], a)) m_valid[k] = 1'b0;
        end
        exp_sc = s;
        @(posedge clk);
        #1;
        cyc++;
        check_outputs("step");
        bus.i_load_reserved_op = 1'b0;
        bus.i_store_cond_op    = 1'b0;
        bus.i_store_op         = 1'b0;
    endtask

    task automatic idle();
        step(0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic clear_model();
        for (int k = 0; k < NH; k++) m_valid[k] = 1'b0;
        exp_sc  = 1'b0;
        exp_hid = '0;
    endtask

    // Entered at posedge+1; reset asserted mid-cycle for two cycles.
    task automatic do_reset();
        #2 reset_n = 1'b0;
        #1;
        clear_model();
        chk("rst_async_sc",   32'(bus.o_sc_success), 32'd0);
        chk("rst_async_hart", 32'(bus.o_sc_hart_id), 32'd0);
        chk("rst_async_resv", 32'(bus.o_resv_valid), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;
        cyc += 3;
        check_outputs("rst_rel");
    endtask

    initial begin
        cyc = 0;
        clear_model();
        for (int k = 0; k < NH; k++) begin
            m_addr[k] = '0;
            m_lr[k]   = 0;
        end
        bus.i_hart_id          = '0;
        bus.i_addr             = '0;
        bus.i_load_reserved_op = 1'b0;
        bus.i_store_cond_op    = 1'b0;
        bus.i_store_op         = 1'b0;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check_outputs("reset");
        reset_n = 1'b1;

        // LR then SC back-to-back succeeds
        step(3, 12'h040, 1, 0, 0);
        chk("t1_resv3_set", 32'(bus.o_resv_valid[3]), 32'd1);
        step(3, 12'h040, 0, 1, 0);
        chk("t1_sc_ok",   32'(bus.o_sc_success), 32'd1);
        chk("t1_sc_hart", 32'(bus.o_sc_hart_id), 32'd3);
        chk("t1_resv3",   32'(bus.o_resv_valid[3]), 32'd0);
        idle();
        chk("t1_sc_pulse", 32'(bus.o_sc_success), 32'd0);

        // Store by another hart kills both reservations in the granule
        step(1, 12'h100, 1, 0, 0);
        step(2, 12'h102, 1, 0, 0);
        step(5, 12'h101, 0, 0, 1);
        chk("t2_resv1", 32'(bus.o_resv_valid[1]), 32'd0);
        chk("t2_resv2", 32'(bus.o_resv_valid[2]), 32'd0);
        step(1, 12'h100, 0, 1, 0);
        chk("t2_sc_fail", 32'(bus.o_sc_success), 32'd0);

        // Successful SC invalidates another hart's matching reservation
        step(0, 12'h200, 1, 0, 0);
        step(4, 12'h200, 1, 0, 0);
        step(0, 12'h200, 0, 1, 0);
        chk("t3_sc_ok", 32'(bus.o_sc_success), 32'd1);
        chk("t3_resv4", 32'(bus.o_resv_valid[4]), 32'd0);
        step(4, 12'h200, 0, 1, 0);
        chk("t3_sc4_fail", 32'(bus.o_sc_success), 32'd0);

        // Mismatched SC fails and still consumes the reservation
        step(6, 12'h300, 1, 0, 0);
        step(6, 12'h304, 0, 1, 0);
        chk("t4_sc_fail", 32'(bus.o_sc_success), 32'd0);
        step(6, 12'h300, 0, 1, 0);
        chk("t4_retry_fail", 32'(bus.o_sc_success), 32'd0);

        // Out-of-range hart: SC fails and reports its ID, LR does nothing
        step(13, 12'h040, 1, 0, 0);
        step(13, 12'h040, 0, 1, 0);
        chk("t6_bad_hart_hid", 32'(bus.o_sc_hart_id), 32'd13);

        // Priority: LR wins over SC and store
        step(8, 12'h080, 1, 1, 1);
        chk("t7_lr_prio", 32'(bus.o_resv_valid[8]), 32'd1);

        // Reset mid-sequence drops reservations
        step(7, 12'h010, 1, 0, 0);
        do_reset();
        step(7, 12'h010, 0, 1, 0);
        chk("t5_sc_after_rst", 32'(bus.o_sc_success), 32'd0);

`ifdef RESV_TIMEOUT_EN
        step(2, 12'h020, 1, 0, 0);
        idle();
        idle();
        step(2, 12'h020, 0, 1, 0);
        chk("to_sc_in_time", 32'(bus.o_sc_success), 32'd1);
        step(2, 12'h020, 1, 0, 0);
        for (int i = 0; i < 4; i++) idle();
        chk("to_resv_gone", 32'(bus.o_resv_valid[2]), 32'd0);
        step(2, 12'h020, 0, 1, 0);
        chk("to_sc_late", 32'(bus.o_sc_success), 32'd0);
`endif

        // Randomized traffic on a narrow address window
        for (int i = 0; i < 2000; i++) begin
            int h;
            int r;
            logic [AW-1:0] a;
            bit lr;
            bit sc;
            bit st;
            h  = $urandom_range(0, 13);
            a  = AW'(12'h040 + $urandom_range(0, 15));
            r  = $urandom_range(0, 9);
            lr = (r <= 2);
            sc = (r >= 3 && r <= 5);
            st = (r == 6 || r == 7);
            if (r == 9) begin
                lr = 1'($urandom_range(0, 1));
                sc = 1'($urandom_range(0, 1));
                st = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 299) == 0) do_reset();
            else step(h, a, lr, sc, st);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
